// File: rtl/uart_tx_fifo_if.sv
// FIFO write port of uart_tx_fifo: a valid/ready handshake that carries one data word.
interface uart_tx_fifo_if #(
  parameter int DATA_W = 9
);
  logic [DATA_W-1:0] s_data;
  logic              s_valid;
  logic              s_ready;

  modport master (output s_data, output s_valid, input s_ready);
  modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/uart_tx_fifo.sv
// UART transmitter with an internal TX FIFO, configurable frame format, break generation
// and optional CTS gating. Bit timing comes from an external oversample tick.
module uart_tx_fifo #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_W     = 9,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        tx_tick,
  uart_tx_fifo_if.slave               s_if,
  input  logic                        fifo_flush,
  input  logic [3:0]                  cfg_data_bits,
  input  logic [2:0]                  cfg_parity,
  input  logic [1:0]                  cfg_stop,
  input  logic                        cfg_msb_first,
  input  logic                        cfg_cts_en,
  input  logic                        cts_n,
  input  logic                        break_req,
  output logic                        tx,
  output logic                        busy,
  output logic                        frame_done,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int TW    = $clog2(OVERSAMPLE);
  localparam int BW    = $clog2(DATA_W + 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;
  localparam logic [2:0] S_BREAK  = 3'd5;

  function automatic logic [BW-1:0] clamp_bits(input logic [3:0] c);
    int v;
    v = int'(c);
    if (v < 5) v = 5;
    if (v > DATA_W) v = DATA_W;
    return BW'(v);
  endfunction

  function automatic logic [DATA_W-1:0] width_mask(input logic [BW-1:0] n);
    logic [DATA_W-1:0] m;
    for (int i = 0; i < DATA_W; i++) m[i] = (i < int'(n));
    return m;
  endfunction

  function automatic logic parity_on(input logic [2:0] mode);
    return (mode >= 3'd1) && (mode <= 3'd4);
  endfunction

  function automatic logic parity_bit(input logic [2:0] mode, input logic [DATA_W-1:0] d);
    case (mode)
      3'd1:    return ^d;
      3'd2:    return ~^d;
      3'd3:    return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_q, rd_q;
  logic [LVL_W-1:0]  level_q;
  logic              ready, push, pop;

  logic [2:0]        state_q, state_d;
  logic [TW-1:0]     tick_q, tick_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [BW-1:0]     nbits_q, nbits_d;
  logic [2:0]        par_q, par_d;
  logic [1:0]        stop_q, stop_d;
  logic              msb_q, msb_d;
  logic              tx_q, tx_d, busy_q, done_q, done_d;
  logic              launch_ok, launch, bit_end, half_end, stop_end;
  logic [BW-1:0]     sel;
  logic [DATA_W-1:0] sh;

  assign ready      = (level_q != LVL_W'(FIFO_DEPTH));
  assign push       = s_if.s_valid && ready;
  assign s_if.s_ready = ready;
  assign fifo_level = level_q;
  assign tx         = tx_q;
  assign busy       = busy_q;
  assign frame_done = done_q;

  // The IDLE term is left out so the same condition serves back-to-back launch from STOP.
  assign launch_ok = (level_q != '0) && !break_req && (!cfg_cts_en || !cts_n);
  assign bit_end   = tx_tick && (tick_q == TW'(OVERSAMPLE - 1));
  assign half_end  = tx_tick && (tick_q == TW'(OVERSAMPLE / 2 - 1));

  always_comb begin
    state_d  = state_q;
    tick_d   = tick_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    nbits_d  = nbits_q;
    par_d    = par_q;
    stop_d   = stop_q;
    msb_d    = msb_q;
    done_d   = 1'b0;
    launch   = 1'b0;
    stop_end = 1'b0;
    pop      = 1'b0;
    if (tx_tick && state_q != S_IDLE) tick_d = bit_end ? '0 : tick_q + TW'(1);
    case (state_q)
      S_IDLE: begin
        if (break_req) begin
          state_d = S_BREAK;
          tick_d  = '0;
        end else if (launch_ok) begin
          launch = 1'b1;
        end
      end
      S_START: if (bit_end) begin
        state_d = S_DATA;
        bit_d   = '0;
      end
      S_DATA: if (bit_end) begin
        if (bit_q == nbits_q - BW'(1)) begin
          state_d = parity_on(par_q) ? S_PARITY : S_STOP;
          bit_d   = '0;
        end else begin
          bit_d = bit_q + BW'(1);
        end
      end
      S_PARITY: if (bit_end) begin
        state_d = S_STOP;
        bit_d   = '0;
      end
      S_STOP: begin
        // bit_q counts completed stop bits; 1.5 stop ends half way through the second one.
        if (stop_q == 2'b01 && bit_q == BW'(1)) begin
          stop_end = half_end;
        end else if (bit_end) begin
          if (stop_q == 2'b00 || bit_q == BW'(1)) stop_end = 1'b1;
          else bit_d = BW'(1);
        end
        if (stop_end) begin
          done_d = 1'b1;
          tick_d = '0;
          if (launch_ok) launch = 1'b1;
          else state_d = S_IDLE;
        end
      end
      S_BREAK: begin
        if (break_req) tick_d = '0;
        else if (bit_end) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (launch) begin
      pop     = 1'b1;
      state_d = S_START;
      tick_d  = '0;
      bit_d   = '0;
      nbits_d = clamp_bits(cfg_data_bits);
      par_d   = cfg_parity;
      stop_d  = cfg_stop;
      msb_d   = cfg_msb_first;
      shift_d = mem_q[rd_q] & width_mask(clamp_bits(cfg_data_bits));
    end
  end

  // Line level is derived from the next state so tx is a clean register output.
  always_comb begin
    sel = msb_d ? (nbits_d - BW'(1) - bit_d) : bit_d;
    sh  = shift_d >> sel;
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = sh[0];
      S_PARITY: tx_d = parity_bit(par_d, shift_d);
      S_BREAK:  tx_d = !break_req;
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      busy_q  <= (state_d != S_IDLE);
      done_q  <= done_d;
      if (fifo_flush) begin
        wr_q    <= '0;
        rd_q    <= '0;
        level_q <= '0;
      end else begin
        if (push) wr_q <= wr_q + PTR_W'(1);
        if (pop)  rd_q <= rd_q + PTR_W'(1);
        case ({push, pop})
          2'b10:   level_q <= level_q + LVL_W'(1);
          2'b01:   level_q <= level_q - LVL_W'(1);
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push && !fifo_flush) mem_q[wr_q] <= s_if.s_data;
    shift_q <= shift_d;
    nbits_q <= nbits_d;
    par_q   <= par_d;
    stop_q  <= stop_d;
    msb_q   <= msb_d;
  end

endmodule
